// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: divisor then dividend arrive on one bus, one quotient bit per SHIFT+SUB pair.
// Latency: done 2N+3 cycles after the start-sampling edge (3 cycles when the divisor is zero).
// No backpressure: start is only sampled in IDLE; results hold until the next operand load.
module seq_restoring_divider #(
    parameter int DATA_WIDTH = 8,
    parameter int STATE_REG  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_input,
    output logic [DATA_WIDTH-1:0] out_Q_reg,
    output logic [DATA_WIDTH-1:0] out_R_reg,
    output logic [DATA_WIDTH-1:0] out_D_reg,
    output logic [STATE_REG-1:0]  p_STATE,
    output logic                  div_by_zero,
    output logic                  done
);

    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [STATE_REG-1:0] {
        IDLE   = STATE_REG'(0),
        LOAD_D = STATE_REG'(1),
        LOAD_N = STATE_REG'(2),
        SHIFT  = STATE_REG'(3),
        SUB    = STATE_REG'(4),
        DONE   = STATE_REG'(5)
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // Remainder carries one extra bit so the shifted value (up to 2^(N+1)-2)
    // is compared against the divisor without overflow.
    logic [N:0]    rx;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] count;
    logic          dbz;

    logic [N:0]    d_ext;
    logic [N:0]    rx_sub;
    logic          rx_ge_d;
    logic          last_bit;

    assign d_ext    = {1'b0, d};
    assign rx_ge_d  = (rx >= d_ext);
    assign rx_sub   = rx - d_ext;
    assign last_bit = (count == CW'(N - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; done is a Moore output of the DONE state.
    always_comb begin
        state_nxt = IDLE;
        done      = 1'b0;
        case (state)
            IDLE:    state_nxt = start ? LOAD_D : IDLE;
            LOAD_D:  state_nxt = LOAD_N;
            LOAD_N:  state_nxt = (d == '0) ? DONE : SHIFT;
            SHIFT:   state_nxt = SUB;
            SUB:     state_nxt = last_bit ? DONE : SHIFT;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift of {Rx,Q}, conditional restore-free subtract.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx    <= '0;
            q     <= '0;
            d     <= '0;
            count <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                LOAD_D: d <= data_input;
                LOAD_N: begin
                    if (d == '0) begin
                        q   <= '1;
                        rx  <= {1'b0, data_input};
                        dbz <= 1'b1;
                    end else begin
                        q     <= data_input;
                        rx    <= '0;
                        count <= '0;
                        dbz   <= 1'b0;
                    end
                end
                SHIFT: begin
                    rx <= {rx[N-1:0], q[N-1]};
                    q  <= {q[N-2:0], 1'b0};
                end
                SUB: begin
                    if (rx_ge_d) begin
                        rx   <= rx_sub;
                        q[0] <= 1'b1;
                    end else begin
                        q[0] <= 1'b0;
                    end
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_Q_reg   = q;
    assign out_R_reg   = rx[N-1:0];
    assign out_D_reg   = d;
    assign p_STATE     = state;
    assign div_by_zero = dbz;

endmodule
